// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the multiply/divide unit.
// Signed MULT/DIV support is controlled by the MULDIV_SIGNED_EN macro (see muldiv_unit).
package muldiv_pkg;

   // Operation select, as decoded from the instruction.
   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_t;

   // Sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   // Widest HI/LO supported by the constant below.
   localparam int MAX_WIDTH = 64;

   // LO value committed on divide-by-zero (all ones, truncated to WIDTH by the user).
   localparam logic [MAX_WIDTH-1:0] DIV0_LO = '1;

   // True for both divide encodings.
   function automatic logic is_div_op(input op_t o);
      return (o == OP_DIVU) || (o == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational iteration of the shift-add multiplier or the
// restoring divider. The accumulator layout is {upper, lower}:
//   multiply: upper = partial product, lower = remaining multiplier bits
//   divide:   upper = partial remainder, lower = dividend bits / quotient bits
module muldiv_iter
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  op_t                  op,
   input  logic [2*WIDTH-1:0]   acc,
   input  logic [WIDTH-1:0]     operand,
   output logic [2*WIDTH-1:0]   acc_next,
   output logic                 q_bit
);

   logic [WIDTH:0] mul_sum;
   logic [WIDTH:0] rem_shift;
   logic [WIDTH:0] rem_diff;

   // Single iteration: add-and-shift for multiply, trial subtract for divide.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      // Remainder shifted left with the next dividend bit brought in.
      rem_shift = acc[2*WIDTH-1:WIDTH-1];
      rem_diff  = rem_shift - {1'b0, operand};
      // No borrow out of the trial subtraction means the divisor fits.
      q_bit     = ~rem_diff[WIDTH];
      if (is_div_op(op)) begin
         acc_next = {(q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                     acc[WIDTH-2:0], q_bit};
      end else begin
         // The carry of the add becomes the new top bit as everything shifts right.
         acc_next = {mul_sum, acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multicycle MULT/MULTU/DIV/DIVU with HI/LO registers.
// Start at edge N; HI/LO commit and done pulses after edge N+WIDTH+1.
// Build option: define MULDIV_SIGNED_EN to make MULT/DIV signed; without it
// op[0] has no effect and both behave as their unsigned forms.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wd,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t               state;
   op_t                  op_reg;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     operand;
   logic [CNT_W-1:0]     count;
   logic                 div_zero;

   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [2*WIDTH-1:0]   acc_next;
   logic                 q_bit;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_fix;
   logic [WIDTH-1:0]     rem_fix;

`ifdef MULDIV_SIGNED_EN
   logic                 sign_a;
   logic                 sign_b;
   logic                 neg_a;
   logic                 neg_b;

   // Signed ops work on magnitudes; the sign is reapplied in FIX.
   always_comb begin
      neg_a = op[0] & a[WIDTH-1];
      neg_b = op[0] & b[WIDTH-1];
      a_mag = neg_a ? -a : a;
      b_mag = neg_b ? -b : b;
   end

   // Sign correction of the finished magnitude result.
   always_comb begin
      prod_fix = (sign_a ^ sign_b) ? -acc : acc;
      quo_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end
`else
   // Unsigned-only build: operands and results pass straight through.
   always_comb begin
      a_mag    = a;
      b_mag    = b;
      prod_fix = acc;
      quo_fix  = acc[WIDTH-1:0];
      rem_fix  = acc[2*WIDTH-1:WIDTH];
   end
`endif

   assign busy = (state != ST_IDLE);

   muldiv_iter #(
      .WIDTH   (WIDTH)
   ) u_iter (
      .op       (op_reg),
      .acc      (acc),
      .operand  (operand),
      .acc_next (acc_next),
      .q_bit    (q_bit)
   );

   // Sequencer, datapath registers and HI/LO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         op_reg   <= OP_MULTU;
         acc      <= '0;
         operand  <= '0;
         count    <= '0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  // An accepted start takes priority over any MT write.
                  op_reg   <= op_t'(op);
                  div_zero <= (b == '0);
                  count    <= '0;
                  if (op[1]) begin
                     acc     <= {{WIDTH{1'b0}}, a_mag};
                     operand <= b_mag;
                  end else begin
                     acc     <= {{WIDTH{1'b0}}, b_mag};
                     operand <= a_mag;
                  end
`ifdef MULDIV_SIGNED_EN
                  sign_a   <= neg_a;
                  sign_b   <= neg_b;
`endif
                  state    <= ST_CALC;
               end else begin
                  if (mthi) hi <= wd;
                  if (mtlo) lo <= wd;
               end
            end
            ST_CALC: begin
               if (is_div_op(op_reg)) begin
                  acc <= {acc_next[2*WIDTH-1:1], q_bit};
               end else begin
                  acc <= acc_next;
               end
               count <= count + 1'b1;
               if (count == LAST_ITER) state <= ST_FIX;
            end
            ST_FIX: begin
               if (is_div_op(op_reg)) begin
                  // On divide-by-zero the remainder path already holds the
                  // dividend magnitude, so the usual remainder fixup gives back a.
                  lo <= div_zero ? DIV0_LO[WIDTH-1:0] : quo_fix;
                  hi <= rem_fix;
               end else begin
                  {hi, lo} <= prod_fix;
               end
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit. Expected HI/LO are queued
// when an operation is issued and checked when done pulses. Expectations for
// MULT/DIV follow the MULDIV_SIGNED_EN build option.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         mthi;
   logic         mtlo;
   logic [W-1:0] wd;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int n_cmp = 0;
   int n_err = 0;

   logic [W-1:0] exp_hi_q[$];
   logic [W-1:0] exp_lo_q[$];

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .mthi  (mthi),
      .mtlo  (mtlo),
      .wd    (wd),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   // Reference model used for the randomised operations.
   function automatic void model(input logic [1:0] o, input logic [W-1:0] x, y,
                                 output logic [W-1:0] eh, output logic [W-1:0] el);
      longint sx, sy, q, r;
      logic [63:0] p;
      bit sgn;
`ifdef MULDIV_SIGNED_EN
      sgn = o[0];
`else
      sgn = 1'b0;
`endif
      if (sgn) begin
         sx = $signed(x);
         sy = $signed(y);
      end else begin
         sx = longint'({32'b0, x});
         sy = longint'({32'b0, y});
      end
      if (!o[1]) begin
         p  = 64'(sx * sy);
         eh = p[63:32];
         el = p[31:0];
      end else if (y == '0) begin
         eh = x;
         el = '1;
      end else begin
         q  = sx / sy;
         r  = sx % sy;
         eh = r[31:0];
         el = q[31:0];
      end
   endfunction

   // Issue one operation, follow it to completion and check it.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input string name,
                         input int inject, input bit mt_on_start);
      int lat;
      int busy_cnt;
      bit held;
      logic [W-1:0] hi0, lo0, ph, pl;
      @(negedge clk);
      hi0   = hi;
      lo0   = lo;
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      mthi  = mt_on_start;
      mtlo  = mt_on_start;
      wd    = 32'h1111_1111;
      exp_hi_q.push_back(eh);
      exp_lo_q.push_back(el);
      @(negedge clk);
      start = 1'b0;
      mthi  = 1'b0;
      mtlo  = 1'b0;
      a     = '0;
      b     = '0;
      lat      = 1;
      busy_cnt = 0;
      held     = 1'b1;
      while (!done && lat < 200) begin
         if (busy) busy_cnt++;
         if (hi !== hi0 || lo !== lo0) held = 1'b0;
         if (lat == inject) begin
            start = 1'b1;
            op    = OP_MULTU;
            a     = 32'd7;
            b     = 32'd9;
            mthi  = 1'b1;
            wd    = 32'hAAAA_5555;
         end else begin
            start = 1'b0;
            mthi  = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      mthi  = 1'b0;
      ph = exp_hi_q.pop_front();
      pl = exp_lo_q.pop_front();
      n_cmp++;
      if (done !== 1'b1) begin
         n_err++;
         $display("FAIL %s timeout: done=%b after %0d cycles, required done=1", name, done, lat);
      end else begin
         $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h (latency %0d)", name, o, x, y, hi, lo, lat - 1);
         n_cmp++;
         if ((lat - 1) !== (W + 1)) begin
            n_err++;
            $display("FAIL %s latency: got %0d cycles, required %0d", name, lat - 1, W + 1);
         end
         n_cmp++;
         if (busy_cnt !== (W + 1)) begin
            n_err++;
            $display("FAIL %s busy_cycles: got %0d, required %0d", name, busy_cnt, W + 1);
         end
         n_cmp++;
         if (held !== 1'b1) begin
            n_err++;
            $display("FAIL %s hilo_hold: hi/lo changed while busy (start hi=%h lo=%h)", name, hi0, lo0);
         end
         n_cmp++;
         if (hi !== ph) begin
            n_err++;
            $display("FAIL %s hi: got %h, required %h", name, hi, ph);
         end
         n_cmp++;
         if (lo !== pl) begin
            n_err++;
            $display("FAIL %s lo: got %h, required %h", name, lo, pl);
         end
         @(negedge clk);
         n_cmp++;
         if (done !== 1'b0) begin
            n_err++;
            $display("FAIL %s done_pulse: done=%b one cycle later, required 0", name, done);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      op    = OP_MULTU;
      a     = '0;
      b     = '0;
      mthi  = 1'b0;
      mtlo  = 1'b0;
      wd    = '0;
      repeat (2) @(negedge clk);
      $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
      n_cmp++;
      if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, required 0", done); end
      n_cmp++;
      if (hi !== '0) begin n_err++; $display("FAIL reset_hi: got %h, required 0", hi); end
      n_cmp++;
      if (lo !== '0) begin n_err++; $display("FAIL reset_lo: got %h, required 0", lo); end
      reset = 1'b0;
   endtask

   task automatic test_mul();
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 0, 1'b0);
`ifdef MULDIV_SIGNED_EN
      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg", 0, 1'b0);
`else
      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB, "mult_neg", 0, 1'b0);
`endif
   endtask

   task automatic test_div();
      run_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7", 0, 1'b0);
`ifdef MULDIV_SIGNED_EN
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2", 0, 1'b0);
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf", 0, 1'b0);
`else
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, "div_neg7_2", 0, 1'b0);
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, "div_ovf", 0, 1'b0);
`endif
   endtask

   task automatic test_div_zero();
      run_op(OP_DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, "divu_by0", 0, 1'b0);
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0_neg", 0, 1'b0);
   endtask

   task automatic test_busy_ignore();
      // start + mthi on cycle 10 of the operation must both be dropped
      run_op(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, "multu_ignore", 10, 1'b0);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL ignore_no_queue: busy=%b after completion, required 0", busy);
      end
   endtask

   task automatic test_mt();
      logic [W-1:0] hi_prev;
      @(negedge clk);
      hi_prev = hi;
      mtlo = 1'b1;
      wd   = 32'hDEAD_BEEF;
      @(negedge clk);
      mtlo = 1'b0;
      $display("mtlo wd=deadbeef -> hi=%h lo=%h", hi, lo);
      n_cmp++;
      if (lo !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mtlo_lo: got %h, required deadbeef", lo); end
      n_cmp++;
      if (hi !== hi_prev) begin n_err++; $display("FAIL mtlo_hi: got %h, required %h", hi, hi_prev); end
      mthi = 1'b1;
      mtlo = 1'b1;
      wd   = 32'h0F0F_1234;
      @(negedge clk);
      mthi = 1'b0;
      mtlo = 1'b0;
      $display("mthi+mtlo wd=0f0f1234 -> hi=%h lo=%h", hi, lo);
      n_cmp++;
      if (hi !== 32'h0F0F_1234) begin n_err++; $display("FAIL mtboth_hi: got %h, required 0f0f1234", hi); end
      n_cmp++;
      if (lo !== 32'h0F0F_1234) begin n_err++; $display("FAIL mtboth_lo: got %h, required 0f0f1234", lo); end
      // MT alongside an accepted start is dropped; the hold check catches a stray write
      run_op(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, "multu_mt_start", 0, 1'b1);
   endtask

   task automatic test_reset_mid();
      bit saw_done;
      @(negedge clk);
      mthi = 1'b1;
      mtlo = 1'b1;
      wd   = 32'h5A5A_5A5A;
      @(negedge clk);
      mthi  = 1'b0;
      mtlo  = 1'b0;
      op    = OP_MULTU;
      a     = 32'd3;
      b     = 32'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      $display("reset mid-CALC: busy=%b hi=%h lo=%h", busy, hi, lo);
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b, required 0", busy); end
      n_cmp++;
      if (hi !== '0) begin n_err++; $display("FAIL midreset_hi: got %h, required 0", hi); end
      n_cmp++;
      if (lo !== '0) begin n_err++; $display("FAIL midreset_lo: got %h, required 0", lo); end
      @(negedge clk);
      reset = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      n_cmp++;
      if (saw_done !== 1'b0) begin n_err++; $display("FAIL midreset_nodone: done pulsed after abort, required none"); end
      run_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_after_reset", 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [1:0]   o;
      logic [W-1:0] x, y, eh, el;
      for (int i = 0; i < 8; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom;
         y = $urandom;
         if (i % 2 == 1) y = y >> $urandom_range(0, 31);
         if (i == 3) y = '0;
         model(o, x, y, eh, el);
         run_op(o, x, y, eh, el, "random", 0, 1'b0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_zero();
      test_busy_ignore();
      test_mt();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multicycle integer multiply/divide unit in the execute stage, beside the ALU. It takes the same rs/rt operands as the ALU and holds results in HI/LO registers. The writeback mux reads HI/LO for MFHI/MFLO. The controller stalls fetch/decode while busy is high.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  input  WIDTH  rs operand (multiplicand / dividend)
b  input  WIDTH  rt operand (multiplier / divisor)
mthi  input  1  write wd into HI (MTHI)
mtlo  input  1  write wd into LO (MTLO)
wd  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in progress
done  output  1  one-cycle pulse when HI/LO are updated by an operation
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation aborts the operation with no partial HI/LO update.
- States:
  - IDLE: busy=0.
  - CALC: WIDTH iterations.
  - FIX: sign correction and HI/LO commit.
- busy = (state != IDLE). done is registered and high only in the cycle after FIX.
- Edge N, in IDLE with start=1: latch operands.
  - Signed ops latch magnitudes and record sign_a and sign_b.
  - Clear accumulator, counter=0, go to CALC.
- CALC: one iteration per edge, edges N+1..N+WIDTH. When the counter reaches WIDTH-1, go to FIX.
  - Multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH product.
  - Divide: restoring, one quotient bit per cycle.
- FIX, edge N+WIDTH+1: commit, go to IDLE, assert done for one cycle.
  - MULT: {hi,lo} = product, negated (2's complement) if sign_a^sign_b.
  - DIV: lo = quotient negated if sign_a^sign_b; hi = remainder negated if sign_a.
  - Unsigned ops: commit without negation.
- Latency: start at edge N, results visible and done=1 after edge N+WIDTH+1 (33 cycles at WIDTH=32).
- Divide by zero (b==0): no trap; lo = all ones, hi = a as presented (raw, no sign fixup). Same latency.
- DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- start while busy: ignored, no queuing.
- mthi/mtlo in IDLE without start: write on the next edge; both may be asserted together.
- mthi/mtlo while busy, or in the same cycle as an accepted start: ignored.
- hi/lo hold their old values throughout CALC. They change only at FIX or on an MT write.

Optional Feature:
MULDIV_SIGNED_EN:
- Defined: MULT/DIV are signed as above.
- Undefined: op[0] is ignored. MULT behaves as MULTU and DIV as DIVU; sign registers and the FIX negation logic are not built. The FIX state remains, so latency is unchanged.

Decomposition:
- Shared package:
  - op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV)
  - state encodings (ST_IDLE, ST_CALC, ST_FIX)
  - DIV0_LO constant (all ones)
- Natural sub-module: muldiv_iter, the combinational single-iteration datapath.
  - Inputs: op, accumulator, operand.
  - Outputs: next accumulator and quotient bit.
  - The FSM, counter and HI/LO registers stay in muldiv_unit.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 cycles done=1 for one cycle, hi=0xFFFFFFFE lo=0x00000001; busy high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB. With MULDIV_SIGNED_EN undefined -> hi=0x00000006 lo=0xFFFFFFEB.
- DIVU a=100 b=7 -> lo=14 hi=2. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
- DIVU a=0x12345678 b=0 -> lo=0xFFFFFFFF hi=0x12345678, done after 33 cycles.
- Assert start and mthi=1 with wd=0xAAAA5555 on cycle 10 of a running MULTU 3*5 -> both ignored; hi=0 lo=15 at completion.
- mtlo wd=0xDEADBEEF in IDLE -> lo=0xDEADBEEF next cycle.
- Reset pulse mid-CALC -> busy=0, hi=lo=0, no done pulse; a following start runs normally.
